// File: rtl/fp_min_scanner_if.sv
// Request/read/result bundle for fp_min_scanner.
// The scanner drives the slave modport; the requester and the distance memory use master.
interface fp_min_scanner_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              rd_visited;
    logic              busy;
    logic              done;
    logic              found;
    logic [ADDR_W-1:0] min_idx;
    logic [31:0]       min_val;

    modport master (
        output start, rd_data, rd_visited,
        input  rd_en, rd_addr, busy, done, found, min_idx, min_val
    );

    modport slave (
        input  start, rd_data, rd_visited,
        output rd_en, rd_addr, busy, done, found, min_idx, min_val
    );
endinterface

// File: rtl/fp_min_scanner.sv
// Sequential minimum search over N_NODES IEEE-754 single distances, skipping visited entries.
// Optional macro FP_MIN_NAN_FILTER_EN also makes NaN entries ineligible.
module fp_comparator (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_lt
);
    // Strict a < b on raw encodings; -0 sorts below +0, equal values are not less.
    always_comb begin
        o_lt = 1'b0;
        if (i_a[31] != i_b[31])
            o_lt = i_a[31];
        else if (i_a[31])
            o_lt = (i_a[30:0] > i_b[30:0]);
        else
            o_lt = (i_a[30:0] < i_b[30:0]);
    end
endmodule

module fp_min_scanner #(
    parameter int unsigned N_NODES = 16,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    fp_min_scanner_if.slave bus
);
    localparam logic [31:0]     C_POS_INF = 32'h7F80_0000;
    localparam logic [ADDR_W:0] C_N       = N_NODES[ADDR_W:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_idx;
    logic              r_min_vld;
    logic [31:0]       r_run_val;
    logic [ADDR_W-1:0] r_run_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_found;
    logic [ADDR_W-1:0] r_min_idx;
    logic [31:0]       r_min_val;

    logic              w_lt;
    logic              w_elig;
    logic              w_take;
    logic              w_nxt_vld;
    logic [31:0]       w_nxt_val;
    logic [ADDR_W-1:0] w_nxt_idx;

    fp_comparator u_cmp (
        .i_a  (bus.rd_data),
        .i_b  (r_run_val),
        .o_lt (w_lt)
    );

`ifdef FP_MIN_NAN_FILTER_EN
    assign w_elig = !bus.rd_visited &&
                    !((bus.rd_data[30:23] == 8'hFF) && (bus.rd_data[22:0] != '0));
`else
    assign w_elig = !bus.rd_visited;
`endif

    // r_pend marks the cycle a read issued one cycle earlier returns its data.
    assign w_take    = r_pend && w_elig && (!r_min_vld || w_lt);
    assign w_nxt_vld = r_min_vld || w_take;
    assign w_nxt_val = w_take ? bus.rd_data : r_run_val;
    assign w_nxt_idx = w_take ? r_pend_idx  : r_run_idx;

    // The first SCAN cycle only loads the address register, so the rd_en strobe
    // trails the state by one cycle and the last read returns during DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_pend     <= 1'b0;
            r_pend_idx <= '0;
            r_min_vld  <= 1'b0;
            r_run_val  <= C_POS_INF;
            r_run_idx  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_found    <= 1'b0;
            r_min_idx  <= '0;
            r_min_val  <= C_POS_INF;
        end else begin
            r_pend     <= r_rd_en;
            r_pend_idx <= r_rd_addr;
            if (w_take) begin
                r_min_vld <= 1'b1;
                r_run_val <= bus.rd_data;
                r_run_idx <= r_pend_idx;
            end

            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state   <= ST_SCAN;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_min_vld <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (r_cnt < C_N) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_cnt[ADDR_W-1:0];
                        r_cnt     <= r_cnt + 1'b1;
                    end else begin
                        r_rd_en   <= 1'b0;
                        r_rd_addr <= '0;
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state   <= ST_DONE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_found   <= w_nxt_vld;
                    r_min_idx <= w_nxt_vld ? w_nxt_idx : '0;
                    r_min_val <= w_nxt_vld ? w_nxt_val : C_POS_INF;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en   = r_rd_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.found   = r_found;
    assign bus.min_idx = r_min_idx;
    assign bus.min_val = r_min_val;
endmodule

// File: tb/tb_fp_min_scanner.sv
// Directed bench for fp_min_scanner with N_NODES=4; expected results are hand-derived.
module tb_fp_min_scanner;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 2;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    fp_min_scanner_if #(.ADDR_W(AW)) bus ();

    fp_min_scanner #(.N_NODES(N), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distance/visited memory with one cycle of read latency.
    logic [31:0]   mem [N];
    logic [N-1:0]  vis;
    logic [AW-1:0] q_addr;
    always @(posedge clk) q_addr <= bus.rd_addr;
    assign bus.rd_data    = mem[q_addr];
    assign bus.rd_visited = vis[q_addr];

    int en_cnt;
    int addr_viol;
    initial begin
        en_cnt    = 0;
        addr_viol = 0;
    end
    always @(negedge clk) begin
        if (bus.rd_en) en_cnt = en_cnt + 1;
        else if (bus.rd_addr != '0) addr_viol = addr_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_search(input int id,
                             input logic [31:0] v0, input logic [31:0] v1,
                             input logic [31:0] v2, input logic [31:0] v3,
                             input logic [3:0] vmask, input bit poke,
                             input logic e_found, input logic [AW-1:0] e_idx,
                             input logic [31:0] e_val);
        int cyc;
        int en0;
        bit got;
        mem[0] = v0; mem[1] = v1; mem[2] = v2; mem[3] = v3;
        vis = vmask;
        @(negedge clk);
        en0 = en_cnt;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk($sformatf("t%0d_busy", id), {31'd0, bus.busy}, 32'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (poke && cyc == 2) bus.start = 1'b1;
            if (poke && cyc == 3) bus.start = 1'b0;
            if (bus.done) got = 1'b1;
        end
        chk($sformatf("t%0d_lat", id), cyc, N + 2);
        chk($sformatf("t%0d_found", id), {31'd0, bus.found}, {31'd0, e_found});
        chk($sformatf("t%0d_idx", id), {30'd0, bus.min_idx}, {30'd0, e_idx});
        chk($sformatf("t%0d_val", id), bus.min_val, e_val);
        chk($sformatf("t%0d_rden", id), en_cnt - en0, N);
        @(posedge clk);
        #1;
        chk($sformatf("t%0d_pulse", id), {31'd0, bus.done}, 32'd0);
        chk($sformatf("t%0d_hold", id), bus.min_val, e_val);
        chk($sformatf("t%0d_idle", id), {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        vis       = '0;
        for (int i = 0; i < int'(N); i++) mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rden", {31'd0, bus.rd_en}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_found", {31'd0, bus.found}, 32'd0);
        chk("rst_val", bus.min_val, 32'h7F80_0000);
        @(negedge clk);
        rst = 1'b0;

        // {3,1,2,5}
        do_search(1, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 32'h40A0_0000,
                  4'b0000, 1'b0, 1'b1, 2'd1, 32'h3F80_0000);
        // tie {2,2,4,2}, start poked mid-scan
        do_search(2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 32'h4000_0000,
                  4'b0000, 1'b1, 1'b1, 2'd0, 32'h4000_0000);
        // {1,-0,+0,0.5}, entry 0 visited
        do_search(3, 32'h3F80_0000, 32'h8000_0000, 32'h0000_0000, 32'h3F00_0000,
                  4'b0001, 1'b0, 1'b1, 2'd1, 32'h8000_0000);
        // all visited
        do_search(4, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                  4'b1111, 1'b0, 1'b0, 2'd0, 32'h7F80_0000);

        // abort on the second SCAN cycle
        mem[0] = 32'h4080_0000; mem[1] = 32'h4040_0000;
        mem[2] = 32'h4110_0000; mem[3] = 32'h4100_0000;
        vis = '0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_rden", {31'd0, bus.rd_en}, 32'd0);
        chk("abort_found", {31'd0, bus.found}, 32'd0);
        chk("abort_val", bus.min_val, 32'h7F80_0000);
        begin
            int dn;
            dn = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk);
                #1;
                if (k == 2) rst = 1'b0;
                if (bus.done) dn++;
            end
            chk("abort_nodone", dn, 0);
        end
        do_search(5, 32'h4080_0000, 32'h4040_0000, 32'h4110_0000, 32'h4100_0000,
                  4'b0000, 1'b0, 1'b1, 2'd1, 32'h4040_0000);

`ifdef FP_MIN_NAN_FILTER_EN
        do_search(6, 32'hFFC0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                  4'b0000, 1'b0, 1'b1, 2'd1, 32'h40C0_0000);
`else
        do_search(6, 32'hFFC0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                  4'b0000, 1'b0, 1'b1, 2'd0, 32'hFFC0_0000);
`endif

        chk("addr_idle_zero", addr_viol, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_min_scanner.md
FP_MIN_SCANNER -- requirements
Module: fp_min_scanner

Interface
REQ-001 Parameter N_NODES, default 16: number of distance entries scanned per search (2..256).
REQ-002 Parameter ADDR_W, default 4: address width, SHALL satisfy 2**ADDR_W >= N_NODES.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a new minimum search; sampled only in IDLE.
REQ-006 rd_en  output  1  read strobe to the distance/visited memory.
REQ-007 rd_addr  output  ADDR_W  entry index being read.
REQ-008 rd_data  input  32  IEEE-754 single distance, valid the cycle after the rd_en cycle.
REQ-009 rd_visited  input  1  visited flag of the same entry, same timing as rd_data.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse when results are valid.
REQ-012 found  output  1  at least one eligible entry existed in the last search.
REQ-013 min_idx  output  ADDR_W  index of the minimum eligible entry.
REQ-014 min_val  output  32  distance of the minimum eligible entry.

Function
REQ-015 FSM states SHALL be IDLE, SCAN, DRAIN, DONE.
REQ-016 IDLE: start=1 at an edge SHALL move to SCAN, clear the running minimum to invalid and zero the address counter.
REQ-017 SCAN: rd_en=1 every cycle, rd_addr = 0, 1, ... N_NODES-1 on consecutive cycles; after address N_NODES-1 is issued, move to DRAIN.
REQ-018 DRAIN: rd_en=0 for one cycle while the last returned entry is evaluated; then move to DONE.
REQ-019 DONE: done=1 for exactly one cycle; min_idx, min_val, found update on the edge entering DONE; then return to IDLE.
REQ-020 Latency: done SHALL be high in the cycle that begins N_NODES+2 edges after the edge that sampled start.
REQ-021 Eligibility: an entry is eligible when rd_visited=0.
REQ-022 The first eligible entry of a search SHALL be taken unconditionally as the running minimum.
REQ-023 Each later eligible entry replaces the running minimum only if it is strictly less, as computed by an instance of fp_comparator (a=rd_data, b=running minimum): sign first (negative < positive, including -0 < +0), then exponent, then mantissa, with the ordering inverted for negatives; equal values are not less.
REQ-024 Ties SHALL therefore resolve to the lowest index.
REQ-025 No eligible entry: found=0, min_idx=0, min_val=32'h7F800000 (+inf).
REQ-026 Outputs SHALL hold their values from DONE until the next DONE; start asserted while busy or in DONE is ignored.
REQ-027 rd_addr SHALL be 0 whenever rd_en=0.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, rd_en=0, rd_addr=0, busy=0, done=0, found=0, min_idx=0, min_val=32'h7F800000, running minimum invalid.
REQ-029 Reset asserted mid-search SHALL abandon the search with no done pulse; the first start after reset release begins a complete new search.

Configuration
REQ-030 Macro FP_MIN_NAN_FILTER_EN defined: an entry whose exponent is 8'hFF with non-zero mantissa (NaN) SHALL also be ineligible, regardless of rd_visited.
REQ-031 Macro undefined: NaN entries are eligible and ordered purely by the sign/exponent/mantissa rule of REQ-023; no extra logic is compiled in.

Verification
REQ-032 N_NODES=4, values {3.0, 1.0, 2.0, 5.0}, all unvisited, start pulse -> done exactly 6 edges after start, found=1, min_idx=1, min_val=32'h3F800000.
REQ-033 Values {2.0, 2.0, 4.0, 2.0}, all unvisited -> min_idx=0 (lowest-index tie), min_val=32'h40000000.
REQ-034 Values {1.0, -0.0, +0.0, 0.5}, visited={1,0,0,0} -> min_idx=1, min_val=32'h80000000.
REQ-035 All entries visited -> found=0, min_idx=0, min_val=32'h7F800000.
REQ-036 rst asserted on the 2nd SCAN cycle, released, start reissued with {4.0, 3.0, 9.0, 8.0} -> no done during the aborted search; then done with min_idx=1, min_val=32'h40400000.
REQ-037 With FP_MIN_NAN_FILTER_EN, entry 0 = 32'hFFC00000, others {6.0, 7.0, 8.0} -> min_idx=1, min_val=32'h40C00000; without the macro -> min_idx=0, min_val=32'hFFC00000.
